// File: rtl/sram_port_arbiter_if.sv
// Bundle of all signals around the shared SRAM port.
// Ports (slave = arbiter side):
//   VGA     : vga_enable, vga_req, vga_address -> vga_read_data, vga_read_valid
//   master  : m_req, m_we, m_address, m_write_data -> m_grant, m_read_data, m_read_valid
//   stats   : stat_clear -> m_stall_cycles
//   SRAM    : SRAM_read_data -> SRAM_address, SRAM_write_data, SRAM_we_n
interface sram_port_arbiter_if #(
   parameter int unsigned ADDR_W = 18,
   parameter int unsigned DATA_W = 16
);
   logic              vga_enable;
   logic              vga_req;
   logic [ADDR_W-1:0] vga_address;
   logic [DATA_W-1:0] vga_read_data;
   logic              vga_read_valid;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_address;
   logic [DATA_W-1:0] m_write_data;
   logic              m_grant;
   logic [DATA_W-1:0] m_read_data;
   logic              m_read_valid;

   logic              stat_clear;
   logic [15:0]       m_stall_cycles;

   logic [ADDR_W-1:0] SRAM_address;
   logic [DATA_W-1:0] SRAM_write_data;
   logic              SRAM_we_n;
   logic [DATA_W-1:0] SRAM_read_data;

   modport slave (
      input  vga_enable, vga_req, vga_address,
      output vga_read_data, vga_read_valid,
      input  m_req, m_we, m_address, m_write_data,
      output m_grant, m_read_data, m_read_valid,
      input  stat_clear,
      output m_stall_cycles,
      output SRAM_address, SRAM_write_data, SRAM_we_n,
      input  SRAM_read_data
   );

   modport master (
      output vga_enable, vga_req, vga_address,
      input  vga_read_data, vga_read_valid,
      output m_req, m_we, m_address, m_write_data,
      input  m_grant, m_read_data, m_read_valid,
      output stat_clear,
      input  m_stall_cycles,
      input  SRAM_address, SRAM_write_data, SRAM_we_n,
      output SRAM_read_data
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between a fixed-priority VGA reader and a
// request/grant master. All SRAM-side signals are registered; each issued
// read carries an owner tag down a pipeline so the returned data is steered
// to the right requester with a one-cycle valid strobe.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sram_port_arbiter_if.slave (VGA, master, stats, SRAM signals)
module sram_port_arbiter #(
   parameter int unsigned ADDR_W       = 18,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned READ_LATENCY = 2
) (
   input logic               clk,
   input logic               rst,
   sram_port_arbiter_if.slave bus
);
   localparam int unsigned TAG_DEPTH = READ_LATENCY + 1;
   localparam int unsigned STALL_W   = 16;
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   typedef enum logic [1:0] {
      TAG_NONE   = 2'd0,
      TAG_VGA    = 2'd1,
      TAG_MASTER = 2'd2
   } tag_t;

   logic              vga_win;
   logic              grant;
   tag_t              issue_tag;
   tag_t              head_tag;
   tag_t              tag_pipe [TAG_DEPTH];

   logic [ADDR_W-1:0] sram_address;
   logic [DATA_W-1:0] sram_write_data;
   logic              sram_we_n;
   logic [DATA_W-1:0] vga_read_data;
   logic              vga_read_valid;
   logic [DATA_W-1:0] m_read_data;
   logic              m_read_valid;
   logic [STALL_W-1:0] stall_cycles;

   // Arbitration: VGA always wins when enabled
   always_comb begin
      vga_win = bus.vga_enable & bus.vga_req;
      grant   = bus.m_req & ~vga_win;
   end

   // Owner of the access issued this cycle (writes return nothing)
   always_comb begin
      issue_tag = TAG_NONE;
      if (vga_win) begin
         issue_tag = TAG_VGA;
      end else if (grant && !bus.m_we) begin
         issue_tag = TAG_MASTER;
      end
   end

   // Head entry lines up with the cycle SRAM_read_data is valid
   assign head_tag = tag_pipe[READ_LATENCY];

   // SRAM-side issue registers; address/data hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_address    <= '0;
         sram_write_data <= '0;
         sram_we_n       <= 1'b1;
      end else begin
         sram_we_n <= 1'b1;
         if (vga_win) begin
            sram_address <= bus.vga_address;
         end else if (grant) begin
            sram_address    <= bus.m_address;
            sram_write_data <= bus.m_write_data;
            sram_we_n       <= ~bus.m_we;
         end
      end
   end

   // Tag shift register; reset discards every in-flight read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAG_DEPTH; i++) begin
            tag_pipe[i] <= TAG_NONE;
         end
      end else begin
         tag_pipe[0] <= issue_tag;
         for (int i = 1; i < TAG_DEPTH; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   // Read return steering
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_read_data  <= '0;
         vga_read_valid <= 1'b0;
         m_read_data    <= '0;
         m_read_valid   <= 1'b0;
      end else begin
         vga_read_valid <= 1'b0;
         m_read_valid   <= 1'b0;
         if (head_tag == TAG_VGA) begin
            vga_read_data  <= bus.SRAM_read_data;
            vga_read_valid <= 1'b1;
         end else if (head_tag == TAG_MASTER) begin
            m_read_data  <= bus.SRAM_read_data;
            m_read_valid <= 1'b1;
         end
      end
   end

   // Saturating master stall counter, clear wins over increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (bus.stat_clear) begin
         stall_cycles <= '0;
      end else if (bus.m_req && !grant && stall_cycles != STALL_MAX) begin
         stall_cycles <= stall_cycles + STALL_W'(1);
      end
   end

   assign bus.m_grant         = grant;
   assign bus.SRAM_address    = sram_address;
   assign bus.SRAM_write_data = sram_write_data;
   assign bus.SRAM_we_n       = sram_we_n;
   assign bus.vga_read_data   = vga_read_data;
   assign bus.vga_read_valid  = vga_read_valid;
   assign bus.m_read_data     = m_read_data;
   assign bus.m_read_valid    = m_read_valid;
   assign bus.m_stall_cycles  = stall_cycles;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: behavioural SRAM with fixed read
// latency, expected returns queued at issue time and matched on valid.
module tb_sram_port_arbiter;
   localparam int unsigned ADDR_W = 18;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned RL     = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      bit                is_vga;
      logic [DATA_W-1:0] data;
      int                cyc;
   } ret_t;

   ret_t              sb[$];
   int                errors = 0;
   int                checks = 0;
   int                cyc    = 0;

   logic [DATA_W-1:0] sram_mem [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] exp_mem  [logic [ADDR_W-1:0]];
   logic [DATA_W-1:0] rd_pipe  [RL];

   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_wd;
   logic              exp_we_n;
   logic [15:0]       stall_m;
   logic [DATA_W-1:0] last_vga;
   logic [DATA_W-1:0] last_m;

   function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
      if (a == 18'h00100) return 16'hBEEF;
      return 16'(a) + 16'h0100;
   endfunction

   function automatic logic [DATA_W-1:0] sram_lookup(input logic [ADDR_W-1:0] a);
      if (sram_mem.exists(a)) return sram_mem[a];
      return dflt(a);
   endfunction

   function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
      if (exp_mem.exists(a)) return exp_mem[a];
      return dflt(a);
   endfunction

   // Behavioural SRAM: data for the address seen in cycle n is driven in cycle n+RL
   initial for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
   always @(posedge clk) begin
      if (!bus.SRAM_we_n) sram_mem[bus.SRAM_address] = bus.SRAM_write_data;
      rd_pipe[0] <= sram_lookup(bus.SRAM_address);
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.SRAM_read_data = rd_pipe[RL-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_models();
      sb.delete();
      exp_addr = '0;
      exp_wd   = '0;
      exp_we_n = 1'b1;
      stall_m  = '0;
      last_vga = '0;
      last_m   = '0;
   endtask

   task automatic drive_idle();
      bus.vga_enable   = 1'b1;
      bus.vga_req      = 1'b0;
      bus.vga_address  = '0;
      bus.m_req        = 1'b0;
      bus.m_we         = 1'b0;
      bus.m_address    = '0;
      bus.m_write_data = '0;
      bus.stat_clear   = 1'b0;
   endtask

   task automatic check_returns();
      ret_t e;
      chk("dual_valid", 32'(bus.vga_read_valid & bus.m_read_valid), 32'd0);
      if (bus.vga_read_valid || bus.m_read_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_valid", 32'({bus.vga_read_valid, bus.m_read_valid}), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("ret_dest_vga", 32'(bus.vga_read_valid), 32'(e.is_vga));
            chk("ret_cycle", 32'(cyc), 32'(e.cyc));
            if (e.is_vga) last_vga = e.data;
            else          last_m   = e.data;
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk("missing_valid", 32'({bus.vga_read_valid, bus.m_read_valid}),
             32'({e.is_vga, ~e.is_vga}));
      end
      chk("vga_read_data", 32'(bus.vga_read_data), 32'(last_vga));
      chk("m_read_data", 32'(bus.m_read_data), 32'(last_m));
   endtask

   // One clock cycle with the inputs currently driven
   task automatic tick();
      logic win, gnt;
      ret_t e;
      #1;
      win = bus.vga_enable & bus.vga_req;
      gnt = bus.m_req & ~win;
      chk("m_grant", 32'(bus.m_grant), 32'(gnt));
      exp_we_n = 1'b1;
      if (win) begin
         exp_addr = bus.vga_address;
         e.is_vga = 1'b1;
         e.data   = exp_rd(bus.vga_address);
         e.cyc    = cyc + 2 + int'(RL);
         sb.push_back(e);
      end else if (gnt) begin
         exp_addr = bus.m_address;
         exp_we_n = ~bus.m_we;
         exp_wd   = bus.m_write_data;
         if (bus.m_we) begin
            exp_mem[bus.m_address] = bus.m_write_data;
         end else begin
            e.is_vga = 1'b0;
            e.data   = exp_rd(bus.m_address);
            e.cyc    = cyc + 2 + int'(RL);
            sb.push_back(e);
         end
      end
      if (bus.stat_clear) stall_m = '0;
      else if (bus.m_req && !gnt && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
      @(posedge clk);
      #1;
      cyc++;
      chk("SRAM_address", 32'(bus.SRAM_address), 32'(exp_addr));
      chk("SRAM_we_n", 32'(bus.SRAM_we_n), 32'(exp_we_n));
      chk("SRAM_write_data", 32'(bus.SRAM_write_data), 32'(exp_wd));
      chk("m_stall_cycles", 32'(bus.m_stall_cycles), 32'(stall_m));
      check_returns();
   endtask

   task automatic idle(input int n);
      drive_idle();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      #1;
      chk("rst_SRAM_address", 32'(bus.SRAM_address), 32'd0);
      chk("rst_SRAM_write_data", 32'(bus.SRAM_write_data), 32'd0);
      chk("rst_SRAM_we_n", 32'(bus.SRAM_we_n), 32'd1);
      chk("rst_vga_read_data", 32'(bus.vga_read_data), 32'd0);
      chk("rst_m_read_data", 32'(bus.m_read_data), 32'd0);
      chk("rst_valids", 32'({bus.vga_read_valid, bus.m_read_valid}), 32'd0);
      chk("rst_stall", 32'(bus.m_stall_cycles), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      reset_models();
   endtask

   initial begin
      reset_models();
      do_reset();
      idle(2);

      // Master-only read; VGA request ignored while disabled
      bus.vga_enable = 1'b0;
      bus.vga_req    = 1'b1;
      bus.m_req      = 1'b1;
      bus.m_address  = 18'h00100;
      tick();
      idle(6);

      // Master write to top of memory
      bus.m_req        = 1'b1;
      bus.m_we         = 1'b1;
      bus.m_address    = 18'h3FFFF;
      bus.m_write_data = 16'h1234;
      tick();
      idle(6);

      // Contention: VGA wins for three cycles, master then issues
      bus.m_req     = 1'b1;
      bus.m_address = 18'h00200;
      for (int i = 0; i < 3; i++) begin
         bus.vga_req     = 1'b1;
         bus.vga_address = ADDR_W'(32'h20 + i);
         tick();
      end
      bus.vga_req = 1'b0;
      tick();
      idle(6);
      chk("stall_after_contention", 32'(bus.m_stall_cycles), 32'd3);

      // Streaming VGA reads, then read back the earlier write
      for (int i = 0; i < 8; i++) begin
         bus.vga_req     = 1'b1;
         bus.vga_address = ADDR_W'(i);
         tick();
      end
      drive_idle();
      bus.m_req     = 1'b1;
      bus.m_address = 18'h3FFFF;
      tick();
      idle(6);

      // Reset with two reads in flight
      bus.m_req     = 1'b1;
      bus.m_address = 18'h00010;
      tick();
      bus.m_address = 18'h00011;
      tick();
      idle(1);
      do_reset();
      idle(6);
      bus.m_req     = 1'b1;
      bus.m_address = 18'h00100;
      tick();
      idle(6);

      // Stall counter saturation and clear
      bus.vga_req = 1'b1;
      bus.m_req   = 1'b1;
      bus.m_address = 18'h00005;
      for (int i = 0; i < 70000; i++) begin
         bus.vga_address = ADDR_W'(i);
         tick();
      end
      chk("stall_saturated", 32'(bus.m_stall_cycles), 32'hFFFF);
      bus.stat_clear = 1'b1;
      tick();
      chk("stall_cleared", 32'(bus.m_stall_cycles), 32'd0);
      bus.stat_clear = 1'b0;
      tick();
      chk("stall_resumed", 32'(bus.m_stall_cycles), 32'd1);
      idle(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
